// File: rtl/muldiv_seq_pkg.sv
// Shared op codes, FSM encoding and per-op control bundle for the RV64M
// multiply/divide sequencer.
package muldiv_seq_pkg;

   localparam int ALUOP_W = 5;

   localparam logic [ALUOP_W-1:0] ALU_MUL    = 5'd16;
   localparam logic [ALUOP_W-1:0] ALU_MULH   = 5'd17;
   localparam logic [ALUOP_W-1:0] ALU_MULHSU = 5'd18;
   localparam logic [ALUOP_W-1:0] ALU_MULHU  = 5'd19;
   localparam logic [ALUOP_W-1:0] ALU_MULW   = 5'd20;
   localparam logic [ALUOP_W-1:0] ALU_DIV    = 5'd21;
   localparam logic [ALUOP_W-1:0] ALU_DIVU   = 5'd22;
   localparam logic [ALUOP_W-1:0] ALU_REM    = 5'd23;
   localparam logic [ALUOP_W-1:0] ALU_REMU   = 5'd24;
   localparam logic [ALUOP_W-1:0] ALU_DIVW   = 5'd25;
   localparam logic [ALUOP_W-1:0] ALU_DIVUW  = 5'd26;
   localparam logic [ALUOP_W-1:0] ALU_REMW   = 5'd27;
   localparam logic [ALUOP_W-1:0] ALU_REMUW  = 5'd28;

   // Iterations per op: one bit per cycle over the full or half word.
   localparam int MDU_ITER_D = 64;
   localparam int MDU_ITER_W = 32;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   typedef struct packed {
      logic is_div;
      logic is_rem;
      logic hi;
      logic word;
      logic neg;
      logic special;
   } mdu_ctl_t;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: MSB-first shift-add for multiply,
// restoring subtract for divide. acc holds {remainder, dividend/quotient}.
module muldiv_iter #(
   parameter int XLEN = 64
) (
   input  logic              is_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opa_i,
   input  logic [XLEN-1:0]   opb_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [XLEN-1:0]   opb_o
);

   logic [XLEN:0] r_sh;
   logic [XLEN:0] diff;

   always_comb begin
      acc_o = '0;
      opb_o = opb_i;
      r_sh  = acc_i[2*XLEN-1:XLEN-1];
      diff  = r_sh - {1'b0, opa_i};
      if (is_div_i) begin
         // Remainder is always below the divisor, so the shifted value fits XLEN+1 bits.
         if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         else             acc_o = {r_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
         acc_o = {acc_i[2*XLEN-2:0], 1'b0} + (opb_i[XLEN-1] ? {{XLEN{1'b0}}, opa_i} : '0);
         opb_o = {opb_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: operand prep, FSM, iteration
// counter and final sign fix around the muldiv_iter step.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUOP_W-1:0] alu_op,
   input  logic [XLEN-1:0]    operator_1,
   input  logic [XLEN-1:0]    operator_2,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    result,
   output logic               busy
);

   localparam int HALF  = XLEN / 2;
   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] N_D = CNT_W'(MDU_ITER_D);
   localparam logic [CNT_W-1:0] N_W = CNT_W'(MDU_ITER_W);

   mdu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d, iter_acc;
   logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, iter_opb;
   mdu_ctl_t          ctl_q, ctl_d;

   logic            op_m, op_div, op_rem, op_hi, op_word, sgn1, sgn2;
   logic            s1, s2, divz, ovf, accept;
   logic [XLEN-1:0] a_ext, b_ext, mag1, mag2, spec_val;

   function automatic logic [XLEN-1:0] word_sext(input logic [HALF-1:0] v);
      return {{HALF{v[HALF-1]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] acc, input mdu_ctl_t c);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   val;
      prod = c.neg ? -acc : acc;
      if (c.is_div) begin
         val = c.is_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
         if (c.neg) val = -val;
      end else begin
         val = c.hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      end
      return c.word ? word_sext(val[HALF-1:0]) : val;
   endfunction

   always_comb begin
      op_m = 1'b1; op_div = 1'b0; op_rem = 1'b0; op_hi = 1'b0;
      op_word = 1'b0; sgn1 = 1'b0; sgn2 = 1'b0;
      case (alu_op)
         ALU_MUL:    begin sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_MULH:   begin op_hi = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_MULHSU: begin op_hi = 1'b1; sgn1 = 1'b1; end
         ALU_MULHU:  op_hi = 1'b1;
         ALU_MULW:   begin op_word = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_DIV:    begin op_div = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_DIVU:   op_div = 1'b1;
         ALU_REM:    begin op_div = 1'b1; op_rem = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_REMU:   begin op_div = 1'b1; op_rem = 1'b1; end
         ALU_DIVW:   begin op_div = 1'b1; op_word = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_DIVUW:  begin op_div = 1'b1; op_word = 1'b1; end
         ALU_REMW:   begin op_div = 1'b1; op_rem = 1'b1; op_word = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         ALU_REMUW:  begin op_div = 1'b1; op_rem = 1'b1; op_word = 1'b1; end
         default:    op_m = 1'b0;
      endcase

      a_ext = operator_1;
      b_ext = operator_2;
      if (op_word) begin
         a_ext = sgn1 ? word_sext(operator_1[HALF-1:0]) : {{HALF{1'b0}}, operator_1[HALF-1:0]};
         b_ext = sgn2 ? word_sext(operator_2[HALF-1:0]) : {{HALF{1'b0}}, operator_2[HALF-1:0]};
      end
      s1   = sgn1 & a_ext[XLEN-1];
      s2   = sgn2 & b_ext[XLEN-1];
      mag1 = s1 ? -a_ext : a_ext;
      mag2 = s2 ? -b_ext : b_ext;

      divz = op_div & (b_ext == '0);
      ovf  = op_div & sgn1 & (op_word
             ? (a_ext[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) && (b_ext[HALF-1:0] == '1)
             : (a_ext == {1'b1, {(XLEN-1){1'b0}}}) && (b_ext == '1));
      spec_val = '0;
      if (divz)     spec_val = op_rem ? a_ext : '1;
      else if (ovf) spec_val = op_rem ? '0 : a_ext;
      if (op_word) spec_val = word_sext(spec_val[HALF-1:0]);
   end

   assign accept = in_valid & in_ready & ~flush;

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .is_div_i (ctl_q.is_div),
      .acc_i    (acc_q),
      .opa_i    (opa_q),
      .opb_i    (opb_q),
      .acc_o    (iter_acc),
      .opb_o    (iter_opb)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      ctl_d    = ctl_q;
      case (state_q)
         MDU_IDLE: if (accept) begin
            state_d       = MDU_CALC;
            cnt_d         = '0;
            ctl_d.is_div  = op_div;
            ctl_d.is_rem  = op_rem;
            ctl_d.hi      = op_hi;
            ctl_d.word    = op_word;
            ctl_d.neg     = (op_div & op_rem) ? s1 : (s1 ^ s2);
            ctl_d.special = ~op_m | divz | ovf;
            acc_d = op_div ? {{XLEN{1'b0}}, (op_word ? mag1 << HALF : mag1)} : '0;
            opa_d = op_div ? mag2 : mag1;
            opb_d = op_div ? '0 : (op_word ? mag2 << HALF : mag2);
            if (~op_m | divz | ovf) result_d = spec_val;
         end
         MDU_CALC: begin
            // Special cases run zero iterations; their result was loaded at accept.
            if (cnt_q == (ctl_q.special ? '0 : (ctl_q.word ? N_W : N_D))) begin
               state_d = MDU_DONE;
               if (!ctl_q.special) result_d = sign_fix(acc_q, ctl_q);
            end else begin
               acc_d = iter_acc;
               opb_d = iter_opb;
               cnt_d = cnt_q + 1'b1;
            end
         end
         MDU_DONE: if (out_ready) state_d = MDU_IDLE;
         default:  state_d = MDU_IDLE;
      endcase
      if (flush) state_d = MDU_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= MDU_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      ctl_q <= ctl_d;
   end

   assign in_ready  = (state_q == MDU_IDLE);
   assign out_valid = (state_q == MDU_DONE);
   assign busy      = (state_q != MDU_IDLE);
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq against a plain-arithmetic RV64M model.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_ready, flush, out_valid, out_ready, busy;
   logic [ALUOP_W-1:0] alu_op;
   logic [63:0]        operator_1, operator_2, result;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   muldiv_seq #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .operator_1(operator_1), .operator_2(operator_2),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic is_word_op(input logic [4:0] op);
      return op == ALU_MULW || op == ALU_DIVW || op == ALU_DIVUW || op == ALU_REMW || op == ALU_REMUW;
   endfunction

   function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, sp;
      logic [127:0]        up;
      logic signed [63:0]  a64, b64;
      logic signed [31:0]  a32, b32;
      logic [31:0]         ua, ub;
      logic [63:0]         res;
      a64 = a; b64 = b; a32 = a[31:0]; b32 = b[31:0]; ua = a[31:0]; ub = b[31:0];
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      res = '0;
      case (op)
         ALU_MUL:    res = a * b;
         ALU_MULH:   begin sp = sa * sb; res = sp[127:64]; end
         ALU_MULHSU: begin sp = sa * $signed({64'b0, b}); res = sp[127:64]; end
         ALU_MULHU:  begin up = {64'b0, a} * {64'b0, b}; res = up[127:64]; end
         ALU_MULW:   res = sx32(ua * ub);
         ALU_DIV:    res = (b == 0) ? ONES : (a == MIN64 && b == ONES) ? a : 64'(a64 / b64);
         ALU_DIVU:   res = (b == 0) ? ONES : a / b;
         ALU_REM:    res = (b == 0) ? a : (a == MIN64 && b == ONES) ? 64'd0 : 64'(a64 % b64);
         ALU_REMU:   res = (b == 0) ? a : a % b;
         ALU_DIVW:   res = (ub == 0) ? ONES : (ua == 32'h8000_0000 && ub == '1) ? sx32(ua) : sx32(32'(a32 / b32));
         ALU_DIVUW:  res = (ub == 0) ? ONES : sx32(ua / ub);
         ALU_REMW:   res = (ub == 0) ? sx32(ua) : (ua == 32'h8000_0000 && ub == '1) ? 64'd0 : sx32(32'(a32 % b32));
         ALU_REMUW:  res = (ub == 0) ? sx32(ua) : sx32(ua % ub);
         default:    res = '0;
      endcase
      return res;
   endfunction

   function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      logic m, dv, sg, wd, bz, ov;
      m  = (op >= ALU_MUL && op <= ALU_REMUW);
      dv = (op >= ALU_DIV && op <= ALU_REMUW);
      sg = (op == ALU_DIV || op == ALU_REM || op == ALU_DIVW || op == ALU_REMW);
      wd = is_word_op(op);
      bz = wd ? (b[31:0] == 0) : (b == 0);
      ov = wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == MIN64 && b == ONES);
      if (!m || (dv && (bz || (sg && ov)))) return 1;
      return wd ? 33 : 65;
   endfunction

   // Caller is at a negedge; the op is accepted on the next rising edge.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int hold);
      logic [63:0] exp_v, held;
      int lat, cyc;
      exp_v = ref_result(op, a, b);
      lat   = ref_lat(op, a, b);
      check({tag, " in_ready before accept"}, {63'b0, in_ready}, 64'd1);
      alu_op = op; operator_1 = a; operator_2 = b; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin
         @(posedge clk); cyc++;
         @(negedge clk);
      end
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      check({tag, " result"}, result, exp_v);
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, " held result"}, result, held);
         check({tag, " held valid/ready"}, {62'b0, out_valid, in_ready}, 64'b10);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " retire valid/ready"}, {62'b0, out_valid, in_ready}, 64'b01);
   endtask

   function automatic logic [63:0] rnd_operand();
      case ($urandom_range(0, 6))
         0:       return 64'd0;
         1:       return ONES;
         2:       return MIN64;
         3:       return 64'($urandom_range(0, 20));
         4:       return {$urandom, 32'h8000_0000};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [4:0] ops [13];
      logic       seen;
      for (int i = 0; i < 13; i++) ops[i] = ALU_MUL + 5'(i);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      alu_op = '0; operator_1 = '0; operator_2 = '0;
      #1;
      check("reset ready/valid/busy", {61'b0, in_ready, out_valid, busy}, 64'b100);
      check("reset result", result, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op("div 7/-2",   ALU_DIV,   64'd7, -64'd2, 0);
      run_op("rem 7%-2",   ALU_REM,   64'd7, -64'd2, 0);
      run_op("divu 5/0",   ALU_DIVU,  64'd5, 64'd0, 0);
      run_op("remu 5%0",   ALU_REMU,  64'd5, 64'd0, 0);
      run_op("div ovf",    ALU_DIV,   MIN64, ONES, 0);
      run_op("rem ovf",    ALU_REM,   MIN64, ONES, 0);
      run_op("mulh -1*-1", ALU_MULH,  ONES, ONES, 0);
      run_op("mulhu max",  ALU_MULHU, ONES, ONES, 0);
      run_op("mulhsu -1*2", ALU_MULHSU, ONES, 64'd2, 0);
      run_op("mulw 2^16^2", ALU_MULW, 64'h10000, 64'h10000, 0);
      run_op("divw ovf",   ALU_DIVW,  64'h8000_0000, ONES, 0);
      run_op("divw -7/2",  ALU_DIVW,  64'hFFFF_FFF9, 64'd2, 0);
      run_op("remw -7%2",  ALU_REMW,  64'hFFFF_FFF9, 64'd2, 0);
      run_op("non-M op",   5'd3,      64'd9, 64'd9, 0);
      run_op("backpressure mul", ALU_MUL, 64'h1234_5678_9ABC_DEF0, -64'd3, 10);
      run_op("back-to-back divu", ALU_DIVU, 64'd1000, 64'd7, 0);

      for (int n = 0; n < 24; n++)
         run_op("random", ops[$urandom_range(0, 12)], rnd_operand(), rnd_operand(),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);

      alu_op = ALU_DIV; operator_1 = 64'd100; operator_2 = 64'd3; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush mid-div state", {61'b0, in_ready, out_valid, busy}, 64'b100);
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         seen |= out_valid;
      end
      check("flush no result", {63'b0, seen}, 64'd0);

      alu_op = ALU_DIV; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush blocks accept", {63'b0, busy}, 64'd0);

      alu_op = ALU_MULHU; operator_1 = ONES; operator_2 = 64'd5; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async reset ready/valid/busy", {61'b0, in_ready, out_valid, busy}, 64'b100);
      check("async reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("after reset div", ALU_DIV, -64'd100, 64'd7, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
